alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 17 +
 rtl/alu_arbiter_alu.sv | 27 ++
 rtl/alu_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU opcode enum and datapath width for alu_arbiter
package alu_arbiter_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SRL  = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational 32-bit ALU shared by the arbiter requesters
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    input  logic              sign,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (alu_op_e'(op))
            ALU_ADD:  result = sign ? (a - b) : (a + b);
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = sign ? DATA_W'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter over one shared ALU with a registered result; ALU_ARB_RR_EN selects round-robin
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    input  logic              req0_sign,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    input  logic              req1_sign,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result
);

    logic              grant0;
    logic              grant1;
    logic              open;
    logic              xfer;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic              alu_sign;
    logic [DATA_W-1:0] alu_result;

`ifdef ALU_ARB_RR_EN
    // rr_ptr names the requester that wins when both are valid
    logic rr_ptr;

    assign grant0 = req0_valid && (!req1_valid || !rr_ptr);
    assign grant1 = req1_valid && (!req0_valid || rr_ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (xfer) begin
            rr_ptr <= !grant1;
        end
    end
`else
    assign grant0 = req0_valid;
    assign grant1 = req1_valid && !req0_valid;
`endif

    assign open       = !rsp_valid || rsp_ready;
    assign req0_ready = grant0 && open && !rst;
    assign req1_ready = grant1 && open && !rst;
    assign xfer       = req0_ready || req1_ready;

    always_comb begin
        alu_a    = grant1 ? req1_a    : req0_a;
        alu_b    = grant1 ? req1_b    : req0_b;
        alu_op   = grant1 ? req1_op   : req0_op;
        alu_sign = grant1 ? req1_sign : req0_sign;
    end

    alu_arbiter_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .sign   (alu_sign),
        .result (alu_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
        end else if (xfer) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant1;
            rsp_result <= alu_result;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule
